// File: rtl/axi4_mem_window_if.sv
`default_nettype none
// ==== axi4_mem_window_if : AXI4 AW/W/B/AR/R bundle for the window bridge -- rev 1.0 ====
interface axi4_mem_window_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic              aw_valid, aw_ready;
  logic [ID_W-1:0]   aw_id;
  logic [ADDR_W-1:0] aw_addr;
  logic [7:0]        aw_len;
  logic [2:0]        aw_size;
  logic [1:0]        aw_burst;
  logic              w_valid, w_ready, w_last;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic              b_valid, b_ready;
  logic [ID_W-1:0]   b_id;
  logic [1:0]        b_resp;
  logic              ar_valid, ar_ready;
  logic [ID_W-1:0]   ar_id;
  logic [ADDR_W-1:0] ar_addr;
  logic [7:0]        ar_len;
  logic [2:0]        ar_size;
  logic [1:0]        ar_burst;
  logic              r_valid, r_ready, r_last;
  logic [ID_W-1:0]   r_id;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;

  modport master (
    output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, input aw_ready,
    output w_valid, w_data, w_strb, w_last, input w_ready,
    input  b_valid, b_id, b_resp, output b_ready,
    output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, input ar_ready,
    input  r_valid, r_id, r_data, r_resp, r_last, output r_ready
  );

  modport slave (
    input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, output aw_ready,
    input  w_valid, w_data, w_strb, w_last, output w_ready,
    output b_valid, b_id, b_resp, input b_ready,
    input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, output ar_ready,
    output r_valid, r_id, r_data, r_resp, r_last, input r_ready
  );
endinterface
`default_nettype wire

// File: rtl/axi4_mem_window.sv
`default_nettype none
// ==== axi4_mem_window : range-checked AXI4 address window, DECERR outside -- rev 1.0 ====
module axi4_mem_window #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 32'h8000_0000,
  parameter int                WINDOW_BYTES = 131072,
  parameter int                ID_W         = 4,
  parameter int                DATA_W       = 64
) (
  input  wire               clk,
  input  wire               rst,
  axi4_mem_window_if.slave  s,
  axi4_mem_window_if.master m,
  output logic [15:0]       err_count
);
  localparam logic [32:0] C_BASE33   = {{(33-ADDR_W){1'b0}}, BASE_ADDR};
  localparam logic [32:0] C_WIN33    = 33'(WINDOW_BYTES);
  localparam logic [2:0]  C_MAX_SIZE = 3'($clog2(DATA_W/8));

  localparam logic [2:0] W_IDLE = 3'd0, W_AW_ISSUE = 3'd1, W_PASS = 3'd2,
                         W_B_WAIT = 3'd3, W_ERR_W = 3'd4, W_ERR_B = 3'd5;
  localparam logic [1:0] R_IDLE = 2'd0, R_AR_ISSUE = 2'd1, R_PASS = 2'd2, R_ERR = 2'd3;

  // Footprint check in 33 bits so the top of the address space cannot wrap into the window.
  function automatic logic legal_f(input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                                   input logic [2:0] size, input logic [1:0] burst);
    logic [32:0] bytes, start;
    bytes = (burst == 2'b00) ? (33'd1 << size) : (({25'd0, len} + 33'd1) << size);
    start = {{(33-ADDR_W){1'b0}}, addr};
    if (burst == 2'b10) start = start & ~(bytes - 33'd1);
    return (start >= C_BASE33) && ((start - C_BASE33 + bytes) <= C_WIN33) &&
           (size <= C_MAX_SIZE) && (burst != 2'b11);
  endfunction

  logic [2:0]        r_wstate, w_wnext;
  logic [1:0]        r_rstate, w_rnext;
  logic [ID_W-1:0]   r_aw_id, r_ar_id;
  logic [ADDR_W-1:0] r_aw_addr, r_ar_addr;
  logic [7:0]        r_aw_len, r_ar_len, r_beat_cnt;
  logic [2:0]        r_aw_size, r_ar_size;
  logic [1:0]        r_aw_burst, r_ar_burst;
  logic              w_aw_hs, w_ar_hs, w_werr_done, w_rerr_done;
  logic [16:0]       w_err_sum;

  assign w_aw_hs = s.aw_valid && s.aw_ready;
  assign w_ar_hs = s.ar_valid && s.ar_ready;

  // ---------------- write channel ----------------
  always_ff @(posedge clk) begin
    if (rst) r_wstate <= W_IDLE;
    else     r_wstate <= w_wnext;
  end

  always_comb begin
    w_wnext = r_wstate;
    case (r_wstate)
      W_IDLE:     if (w_aw_hs) w_wnext = legal_f(s.aw_addr, s.aw_len, s.aw_size, s.aw_burst)
                                         ? W_AW_ISSUE : W_ERR_W;
      W_AW_ISSUE: if (m.aw_ready) w_wnext = W_PASS;
      W_PASS:     if (s.w_valid && m.w_ready && s.w_last) w_wnext = W_B_WAIT;
      W_B_WAIT:   if (m.b_valid && s.b_ready) w_wnext = W_IDLE;
      W_ERR_W:    if (s.w_valid && s.w_last) w_wnext = W_ERR_B;
      W_ERR_B:    if (s.b_ready) w_wnext = W_IDLE;
      default:    w_wnext = W_IDLE;
    endcase
  end

  always_comb begin
    s.aw_ready = 1'b0;
    m.aw_valid = 1'b0;
    m.w_valid  = 1'b0;
    s.w_ready  = 1'b0;
    s.b_valid  = 1'b0;
    s.b_id     = r_aw_id;
    s.b_resp   = 2'b11;
    m.b_ready  = 1'b0;
    case (r_wstate)
      W_IDLE:     s.aw_ready = !rst;
      W_AW_ISSUE: m.aw_valid = 1'b1;
      W_PASS: begin
        m.w_valid = s.w_valid;
        s.w_ready = m.w_ready && !rst;
      end
      W_B_WAIT: begin
        s.b_valid = m.b_valid;
        s.b_id    = m.b_id;
        s.b_resp  = m.b_resp;
        m.b_ready = s.b_ready;
      end
      W_ERR_W:    s.w_ready = !rst;
      W_ERR_B:    s.b_valid = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_aw_hs) begin
      r_aw_id    <= s.aw_id;
      r_aw_addr  <= s.aw_addr - BASE_ADDR;
      r_aw_len   <= s.aw_len;
      r_aw_size  <= s.aw_size;
      r_aw_burst <= s.aw_burst;
    end
  end

  assign m.aw_id    = r_aw_id;
  assign m.aw_addr  = r_aw_addr;
  assign m.aw_len   = r_aw_len;
  assign m.aw_size  = r_aw_size;
  assign m.aw_burst = r_aw_burst;
  assign m.w_data   = s.w_data;
  assign m.w_strb   = s.w_strb;
  assign m.w_last   = s.w_last;

  // ---------------- read channel ----------------
  always_ff @(posedge clk) begin
    if (rst) r_rstate <= R_IDLE;
    else     r_rstate <= w_rnext;
  end

  always_comb begin
    w_rnext = r_rstate;
    case (r_rstate)
      R_IDLE:     if (w_ar_hs) w_rnext = legal_f(s.ar_addr, s.ar_len, s.ar_size, s.ar_burst)
                                         ? R_AR_ISSUE : R_ERR;
      R_AR_ISSUE: if (m.ar_ready) w_rnext = R_PASS;
      R_PASS:     if (m.r_valid && s.r_ready && m.r_last) w_rnext = R_IDLE;
      R_ERR:      if (s.r_ready && (r_beat_cnt == 8'd0)) w_rnext = R_IDLE;
      default:    w_rnext = R_IDLE;
    endcase
  end

  always_comb begin
    s.ar_ready = 1'b0;
    m.ar_valid = 1'b0;
    s.r_valid  = 1'b0;
    s.r_id     = r_ar_id;
    s.r_data   = '0;
    s.r_resp   = 2'b11;
    s.r_last   = (r_beat_cnt == 8'd0);
    m.r_ready  = 1'b0;
    case (r_rstate)
      R_IDLE:     s.ar_ready = !rst;
      R_AR_ISSUE: m.ar_valid = 1'b1;
      R_PASS: begin
        s.r_valid = m.r_valid;
        s.r_id    = m.r_id;
        s.r_data  = m.r_data;
        s.r_resp  = m.r_resp;
        s.r_last  = m.r_last;
        m.r_ready = s.r_ready;
      end
      R_ERR:      s.r_valid = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_ar_hs) begin
      r_ar_id    <= s.ar_id;
      r_ar_addr  <= s.ar_addr - BASE_ADDR;
      r_ar_len   <= s.ar_len;
      r_ar_size  <= s.ar_size;
      r_ar_burst <= s.ar_burst;
      r_beat_cnt <= s.ar_len;
    end else if (r_rstate == R_ERR && s.r_ready) begin
      r_beat_cnt <= r_beat_cnt - 8'd1;
    end
  end

  assign m.ar_id    = r_ar_id;
  assign m.ar_addr  = r_ar_addr;
  assign m.ar_len   = r_ar_len;
  assign m.ar_size  = r_ar_size;
  assign m.ar_burst = r_ar_burst;

  // ---------------- error counter ----------------
  assign w_werr_done = (r_wstate == W_ERR_B) && s.b_ready;
  assign w_rerr_done = (r_rstate == R_ERR) && s.r_ready && (r_beat_cnt == 8'd0);
  assign w_err_sum   = {1'b0, err_count} + {16'd0, w_werr_done} + {16'd0, w_rerr_done};

  always_ff @(posedge clk) begin
    if (rst)               err_count <= 16'd0;
    else if (w_err_sum[16]) err_count <= 16'hFFFF;
    else                   err_count <= w_err_sum[15:0];
  end
endmodule
`default_nettype wire

// File: doc/axi4_mem_window.md
# axi4_mem_window

AXI4 address-window bridge placed between the Rocket `m_axi_mem` master port and the `axi4_full_ram` slave. It replaces the bare `addr - 0x8000_0000` subtraction with a registered, range-checked translation. In-window bursts are forwarded to RAM with rebased addresses. Out-of-window or illegal bursts are terminated locally with DECERR, so that a stray CPU access can never alias into RAM or hang the bus.

## Interface
- BASE_ADDR, 32'h8000_0000, first CPU byte address mapped to RAM offset 0
- WINDOW_BYTES, 131072, window size in bytes; power of two
- ID_W, 4, AXI ID width
- ADDR_W, 32, address width
- DATA_W, 64, data width; beat size is DATA_W/8 bytes
- clk  in  1  single clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- s_aw_*/s_w_*/s_b_*/s_ar_*/s_r_*  slave side (from CPU). Signals: valid, ready, id[ID_W], addr[ADDR_W], len[8], size[3], burst[2]; w: data, strb[DATA_W/8], last; b: id, resp[2]; r: id, data, resp, last.
- m_aw_*/m_w_*/m_b_*/m_ar_*/m_r_*  master side (to RAM), same signal set. Addresses are rebased.
- err_count  out  16  saturating count of DECERR bursts (reads plus writes)

## Operation
- Window check, evaluated on AW or AR acceptance:
  - bytes = (len+1) << size, computed in 33-bit arithmetic.
  - start = addr for INCR. For FIXED, start = addr and bytes = 1<<size. For WRAP, start = addr aligned down to bytes.
  - The burst is legal when all of the following hold: start >= BASE_ADDR; start - BASE_ADDR + bytes <= WINDOW_BYTES; size <= log2(DATA_W/8); burst != 2'b11.
- Legal bursts:
  - Translated address m_*_addr = s_*_addr - BASE_ADDR, truncated to ADDR_W.
  - id, len, size and burst pass unchanged.
- Write FSM states: IDLE, AW_ISSUE, W_PASS, B_WAIT, ERR_W, ERR_B.
  - IDLE: s_aw_ready=1. On handshake, latch the fields and go to AW_ISSUE if legal, else ERR_W.
  - AW_ISSUE: m_aw_valid=1 from the register. On m_aw handshake, go to W_PASS.
  - W_PASS: W is passed through combinationally (m_w_valid=s_w_valid, s_w_ready=m_w_ready). On a handshake with last=1, go to B_WAIT.
  - B_WAIT: B is passed through. On handshake, go to IDLE.
  - ERR_W: s_w_ready=1 and beats are discarded. On a beat with last=1, go to ERR_B.
  - ERR_B: s_b_valid=1, resp=2'b11, id=latched. On s_b_ready, increment err_count and go to IDLE.
- Read FSM states: IDLE, AR_ISSUE, R_PASS, ERR_R.
  - IDLE: s_ar_ready=1. On handshake, latch the fields and go to AR_ISSUE if legal, else ERR_R with beat counter = len.
  - AR_ISSUE: m_ar_valid=1. On handshake, go to R_PASS.
  - R_PASS: R is passed through. On a handshake with last=1, go to IDLE.
  - ERR_R: s_r_valid=1, data=0, resp=2'b11, id=latched, last=(counter==0).
    - The counter decrements on each handshake.
    - On the last handshake, increment err_count and go to IDLE.
- Read and write FSMs run independently. At most one outstanding burst per direction.
- W beats arriving before AW is accepted are held off: s_w_ready=0 outside W_PASS and ERR_W.
- err_count saturates at 16'hFFFF. A read and a write error completing in the same cycle add 2.

## Timing
- Reset (rst=1 at a clock edge):
  - Both FSMs go to IDLE. err_count=0.
  - All registered valids are 0.
  - All s_*_ready outputs are forced to 0 while rst=1.
- Reset mid-burst abandons the transaction with no flush. The bench must reset the RAM together with this block.
- Address latency: s_aw/ar handshake in cycle N gives m_aw/ar_valid in cycle N+1, held until ready.
- Data paths W, R and B add zero cycles.
- Error timing:
  - ERR_B s_b_valid is asserted the cycle after the wlast handshake.
  - The first ERR_R beat is asserted the cycle after the AR handshake. Beats are back-to-back while s_r_ready=1.
- Valid is never dropped without a handshake. Payload is stable while valid && !ready.
- s_aw_ready and s_ar_ready are 0 in every non-IDLE state.

## Test plan
- Legal write: INCR AW addr=0x8000_0100, len=3, size=3 → m_aw_addr=0x0100, 4 beats pass through, B resp=0, err_count=0.
- Legal read: INCR AR addr=0x8001_FFE0, len=3, size=3 (ends exactly at the window top) → m_ar_addr=0x1FFE0, 4 beats returned, last on beat 4.
- Overrun read: AR addr=0x8001_FFF8, len=1, size=3 → m_ar_valid is never asserted, 2 beats with resp=3 and data=0, last on beat 2, err_count=1.
- Below-base write: AW addr=0x7FFF_FFF8, len=2 → 3 W beats sunk, B resp=3 with matching id, m_w_valid stays 0, err_count increments.
- Illegal size or burst: AR size=4, then AR burst=2'b11 → each returns DECERR of len+1 beats, err_count increments by 2.
- Backpressure and reset: hold m_r_ready low... and s_r_ready low mid-ERR_R for 5 cycles → payload stable. Assert rst mid-burst → all valids 0 the next cycle, err_count=0.
